// File: rtl/mem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte-to-word packing ratio.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian word from a byte stream; the first byte lands in the LSB lane.
// word is combinational so the owner can capture the complete word on the word_full cycle.
module byte_packer
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [7:0]       in_byte,
  output logic [WIDTH-1:0] word,
  output logic             word_full
);

  logic [1:0]       idx_q;
  logic [WIDTH-1:0] asm_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    word = asm_q;
    if (load) word[{idx_q, 3'b000} +: 8] = in_byte;
    word_full = load && (idx_q == 2'(BYTES_PER_WORD - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (load) begin
      idx_q <= idx_q + 2'd1;
      asm_q <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as packed 32-bit words at consecutive
// addresses, holding the core off while the image is partly written.
module imem_loader
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      word_count,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             write_enable,
  output logic [31:0]      write_addr,
  output logic [WIDTH-1:0] write_data,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  loader_state_t    state_q, state_d;
  logic [31:0]      count_q;
  logic [31:0]      word_cnt_q;
  logic [31:0]      addr_q;
  logic [WIDTH-1:0] packed_word;
  logic             word_full;
  logic             start_ok;
  logic             accept;
  logic             count_bad;

  assign start_ok  = start && (state_q == IDLE || state_q == DONE);
  assign count_bad = (word_count == 32'd0) || (word_count > 32'(SIZE));
  assign accept    = in_valid && in_ready;

  byte_packer #(.WIDTH(WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .load      (accept),
    .in_byte   (in_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = count_bad ? DONE : RECV;
      RECV:       if (word_full) state_d = WRITE;
      WRITE:      state_d = (word_cnt_q + 32'd1 == count_q) ? DONE : RECV;
      default:    state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == RECV);
  assign write_enable = (state_q == WRITE);
  assign busy         = (state_q == RECV) || (state_q == WRITE);
  assign core_hold    = busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      write_addr <= '0;
      write_data <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        count_q    <= word_count;
        word_cnt_q <= '0;
        addr_q     <= '0;
        done       <= count_bad;
        error      <= (word_count > 32'(SIZE));
      end
      // Output address/data are captured once per word and held between strobes.
      if (word_full) begin
        write_addr <= addr_q;
        write_data <= packed_word;
      end
      if (state_q == WRITE) begin
        addr_q     <= addr_q + 32'd1;
        word_cnt_q <= word_cnt_q + 32'd1;
        if (state_d == DONE) done <= 1'b1;
      end
    end
  end

endmodule
